gba_rom_responder: RTL and testbench

- Parametrised GBA cartridge ROM-bus responder.
- Captures the full 24-bit GBA address (AH + AD) on /CS falling and auto-increments it on each /RD rising edge. Serves 16-bit words from an external synchronous memory with configurable latency, using a one-word prefetch. Out-of-range reads return open-bus data.
- The pad tristate (SB_IO) is instantiated by the parent. This block only drives ad_out/ad_oe and reads ad_in.

---
 rtl/gba_rom_responder.sv | 137 +++++++++++++
 tb/tb_gba_rom_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gba_rom_responder.sv
// GBA cartridge ROM-bus responder: captures the 24-bit bus address, auto-increments
// it per read strobe and serves words from a latency-configurable synchronous memory.
module gba_rom_responder #(
  parameter int unsigned ROM_AW      = 9,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned SYNC_STAGES = 3,
  parameter bit          OPEN_BUS    = 1'b1,
  parameter logic [15:0] FILL        = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cart_cs_n,
  input  logic              cart_rd_n,
  input  logic [7:0]        cart_ah,
  input  logic [15:0]       ad_in,
  output logic [15:0]       ad_out,
  output logic              ad_oe,
  output logic              mem_req,
  output logic [ROM_AW-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic              underrun,
  output logic [15:0]       read_count
);

  typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync, rd_sync;
  logic                   cs_fall, cs_rise, rd_fall, rd_rise;
  logic [23:0]            addr, addr_next;
  logic                   addr_upd, in_range, next_in_range;
  logic [2:0]             lat_cnt;
  logic [15:0]            pf_data, fetch_data;
  logic                   pf_valid, pending, fetch_done;
  logic                   cs_low;

  // The pad enable bypasses the synchronisers so the bus turns around immediately.
  assign ad_oe  = !rst && !cart_cs_n && !cart_rd_n;
  assign cs_low = !cs_sync[SYNC_STAGES-1];

  // NOTE: synchroniser flops reset to 1 (idle bus) so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync <= '1;
      rd_sync <= '1;
      cs_fall <= 1'b0;
      cs_rise <= 1'b0;
      rd_fall <= 1'b0;
      rd_rise <= 1'b0;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], cart_cs_n};
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], cart_rd_n};
      cs_fall <= cs_sync[SYNC_STAGES-1] && !cs_sync[SYNC_STAGES-2];
      cs_rise <= !cs_sync[SYNC_STAGES-1] && cs_sync[SYNC_STAGES-2];
      rd_fall <= rd_sync[SYNC_STAGES-1] && !rd_sync[SYNC_STAGES-2];
      rd_rise <= !rd_sync[SYNC_STAGES-1] && rd_sync[SYNC_STAGES-2];
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    addr_upd  = 1'b0;
    addr_next = addr;
    if (cs_fall) begin
      addr_upd  = 1'b1;
      addr_next = {cart_ah, ad_in};
    end else if (rd_rise && cs_low) begin
      addr_upd  = 1'b1;
      addr_next = {addr[23:16], addr[15:0] + 16'd1};
    end
    in_range      = (addr[23:ROM_AW] == '0);
    next_in_range = (addr_next[23:ROM_AW] == '0);
    fetch_data    = in_range ? mem_rdata : (OPEN_BUS ? addr[15:0] : FILL);
    // A restart or deselect in the landing cycle discards the response.
    fetch_done    = (state == FETCH) && !addr_upd && !cs_rise &&
                    (!in_range || (lat_cnt == 3'(MEM_LATENCY)));
  end

  // NOTE: all sequential state uses non-blocking assignments to avoid update-order races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      lat_cnt    <= '0;
      pf_data    <= '0;
      pf_valid   <= 1'b0;
      pending    <= 1'b0;
      ad_out     <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      underrun   <= 1'b0;
      read_count <= '0;
    end else begin
      mem_req  <= 1'b0;
      underrun <= 1'b0;

      if (rd_rise && cs_low) read_count <= read_count + 16'd1;
      if (addr_upd) addr <= addr_next;

      if (cs_rise) begin
        state    <= IDLE;
        pf_valid <= 1'b0;
        pending  <= 1'b0;
      end else if (addr_upd) begin
        state    <= FETCH;
        pf_valid <= 1'b0;
        lat_cnt  <= '0;
        mem_req  <= next_in_range;
        if (next_in_range) mem_addr <= addr_next[ROM_AW-1:0];
      end else if (state == FETCH) begin
        if (fetch_done) begin
          pf_data  <= fetch_data;
          pf_valid <= 1'b1;
          state    <= READY;
        end else begin
          lat_cnt  <= lat_cnt + 3'd1;
        end
      end

      // A read that outruns the prefetch is answered the cycle the data lands.
      if (!cs_rise) begin
        if (rd_fall && pf_valid) begin
          ad_out <= pf_data;
        end else begin
          if (rd_fall) underrun <= 1'b1;
          if (fetch_done && (pending || rd_fall)) begin
            ad_out  <= fetch_data;
            pending <= 1'b0;
          end else if (rd_fall) begin
            pending <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gba_rom_responder.sv
// Directed bench for gba_rom_responder: three parameterisations share one cartridge
// bus, each backed by its own behavioural synchronous memory.
module tb_gba_rom_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1, rd_n = 1'b1;
  logic [7:0]  ah = '0;
  logic [15:0] ad_in = '0;

  // a: ROM_AW=9 L=1 open bus; b: ROM_AW=16 L=1; c: ROM_AW=9 L=4 fill
  logic [15:0] ad_out_a, ad_out_b, ad_out_c;
  logic        ad_oe_a, ad_oe_b, ad_oe_c;
  logic        req_a, req_b, req_c;
  logic [8:0]  maddr_a, maddr_c;
  logic [15:0] maddr_b;
  logic [15:0] rdata_a, rdata_b, rdata_c;
  logic        ur_a, ur_b, ur_c;
  logic [15:0] rc_a, rc_b, rc_c;

  logic [15:0] mem_a [512];
  logic [15:0] mem_b [65536];
  logic [15:0] mem_c [512];
  logic [15:0] pipe_c [4];

  int checks = 0;
  int errors = 0;
  int req_cnt_a = 0, req_cnt_b = 0, req_cnt_c = 0;
  int ur_cnt_a = 0, ur_cnt_b = 0, ur_cnt_c = 0;

  always #5 clk = ~clk;

  gba_rom_responder #(.ROM_AW(9), .MEM_LATENCY(1), .SYNC_STAGES(3), .OPEN_BUS(1'b1), .FILL(16'hFFFF)) dut_a (
    .clk(clk), .rst(rst), .cart_cs_n(cs_n), .cart_rd_n(rd_n), .cart_ah(ah), .ad_in(ad_in),
    .ad_out(ad_out_a), .ad_oe(ad_oe_a), .mem_req(req_a), .mem_addr(maddr_a), .mem_rdata(rdata_a),
    .underrun(ur_a), .read_count(rc_a));

  gba_rom_responder #(.ROM_AW(16), .MEM_LATENCY(1), .SYNC_STAGES(3), .OPEN_BUS(1'b1), .FILL(16'hFFFF)) dut_b (
    .clk(clk), .rst(rst), .cart_cs_n(cs_n), .cart_rd_n(rd_n), .cart_ah(ah), .ad_in(ad_in),
    .ad_out(ad_out_b), .ad_oe(ad_oe_b), .mem_req(req_b), .mem_addr(maddr_b), .mem_rdata(rdata_b),
    .underrun(ur_b), .read_count(rc_b));

  gba_rom_responder #(.ROM_AW(9), .MEM_LATENCY(4), .SYNC_STAGES(3), .OPEN_BUS(1'b0), .FILL(16'hFFFF)) dut_c (
    .clk(clk), .rst(rst), .cart_cs_n(cs_n), .cart_rd_n(rd_n), .cart_ah(ah), .ad_in(ad_in),
    .ad_out(ad_out_c), .ad_oe(ad_oe_c), .mem_req(req_c), .mem_addr(maddr_c), .mem_rdata(rdata_c),
    .underrun(ur_c), .read_count(rc_c));

  // Behavioural memories: data valid exactly MEM_LATENCY cycles after the request.
  always @(posedge clk) begin
    if (req_a) rdata_a <= mem_a[maddr_a];
    if (req_b) rdata_b <= mem_b[maddr_b];
    pipe_c[0] <= req_c ? mem_c[maddr_c] : 16'h0BAD;
    for (int k = 1; k < 4; k++) pipe_c[k] <= pipe_c[k-1];
  end
  assign rdata_c = pipe_c[3];

  always @(negedge clk) begin
    if (req_a) req_cnt_a++;
    if (req_b) req_cnt_b++;
    if (req_c) req_cnt_c++;
    if (ur_a) ur_cnt_a++;
    if (ur_b) ur_cnt_b++;
    if (ur_c) ur_cnt_c++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_select(input logic [7:0] h, input logic [15:0] a);
    ah = h; ad_in = a; cs_n = 1'b0;
    cycles(8);
  endtask

  task automatic bus_release();
    cs_n = 1'b1;
    cycles(10);
  endtask

  task automatic read_word(output logic [15:0] wa, output logic [15:0] wb,
                           output logic [15:0] wc, output logic oe);
    rd_n = 1'b0;
    cycles(7);
    wa = ad_out_a; wb = ad_out_b; wc = ad_out_c; oe = ad_oe_a;
    cycles(1);
    rd_n = 1'b1;
    cycles(8);
  endtask

  task automatic test_reset();
    cs_n = 1'b0; rd_n = 1'b0;
    cycles(2);
    checks++;
    if (ad_oe_a !== 1'b0) begin errors++; $display("FAIL oe_in_reset got %b want 0", ad_oe_a); end
    cs_n = 1'b1; rd_n = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(20);
    checks++;
    if (ad_oe_a !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", ad_oe_a); end
    checks++;
    if (ad_out_a !== 16'h0000) begin errors++; $display("FAIL reset_ad_out got %h want 0000", ad_out_a); end
    checks++;
    if (ad_out_c !== 16'h0000) begin errors++; $display("FAIL reset_ad_out_c got %h want 0000", ad_out_c); end
    checks++;
    if (req_cnt_a + req_cnt_b + req_cnt_c !== 0) begin
      errors++; $display("FAIL reset_mem_req got %0d pulses want 0", req_cnt_a + req_cnt_b + req_cnt_c);
    end
    checks++;
    if (rc_a !== 16'd0) begin errors++; $display("FAIL reset_read_count got %0d want 0", rc_a); end
  endtask

  task automatic test_basic();
    logic [15:0] wa, wb, wc;
    logic        oe;
    bus_select(8'h00, 16'h0010);
    read_word(wa, wb, wc, oe);
    checks++;
    if (wa !== 16'h1234) begin errors++; $display("FAIL basic_w0_a got %h want 1234", wa); end
    checks++;
    if (wc !== 16'h1234) begin errors++; $display("FAIL basic_w0_c got %h want 1234", wc); end
    checks++;
    if (oe !== 1'b1) begin errors++; $display("FAIL basic_oe got %b want 1", oe); end
    read_word(wa, wb, wc, oe);
    checks++;
    if (wa !== 16'hABCD) begin errors++; $display("FAIL basic_w1_a got %h want abcd", wa); end
    checks++;
    if (wc !== 16'hABCD) begin errors++; $display("FAIL basic_w1_c got %h want abcd", wc); end
    checks++;
    if (rc_a !== 16'd2) begin errors++; $display("FAIL basic_read_count got %0d want 2", rc_a); end
    checks++;
    if (ur_cnt_a + ur_cnt_c !== 0) begin
      errors++; $display("FAIL basic_underrun got %0d want 0", ur_cnt_a + ur_cnt_c);
    end
    bus_release();
  endtask

  task automatic test_wrap();
    logic [15:0] wa, wb, wc;
    logic        oe;
    bus_select(8'h00, 16'hFFFF);
    read_word(wa, wb, wc, oe);
    checks++;
    if (wb !== 16'hF00F) begin errors++; $display("FAIL wrap_ffff got %h want f00f", wb); end
    checks++;
    if (wa !== 16'hFFFF) begin errors++; $display("FAIL wrap_openbus_a got %h want ffff", wa); end
    read_word(wa, wb, wc, oe);
    checks++;
    if (wb !== 16'h0A0A) begin errors++; $display("FAIL wrap_0000 got %h want 0a0a", wb); end
    read_word(wa, wb, wc, oe);
    checks++;
    if (wb !== 16'h1B1B) begin errors++; $display("FAIL wrap_0001 got %h want 1b1b", wb); end
    checks++;
    if (rc_b !== 16'd5) begin errors++; $display("FAIL wrap_read_count got %0d want 5", rc_b); end
    bus_release();
  endtask

  task automatic test_out_of_range();
    logic [15:0] wa, wb, wc;
    logic        oe;
    int          ra, rcc;
    ra = req_cnt_a; rcc = req_cnt_c;
    bus_select(8'h00, 16'h0200);
    read_word(wa, wb, wc, oe);
    checks++;
    if (wa !== 16'h0200) begin errors++; $display("FAIL oor_openbus got %h want 0200", wa); end
    checks++;
    if (wc !== 16'hFFFF) begin errors++; $display("FAIL oor_fill got %h want ffff", wc); end
    checks++;
    if (wb !== 16'hDEAD) begin errors++; $display("FAIL oor_inrange_b got %h want dead", wb); end
    checks++;
    if (req_cnt_a - ra !== 0) begin errors++; $display("FAIL oor_req_a got %0d want 0", req_cnt_a - ra); end
    checks++;
    if (req_cnt_c - rcc !== 0) begin errors++; $display("FAIL oor_req_c got %0d want 0", req_cnt_c - rcc); end
    bus_release();
  endtask

  task automatic test_underrun();
    int u0, first_ur, first_dat;
    u0 = ur_cnt_c; first_ur = -1; first_dat = -1;
    ah = 8'h00; ad_in = 16'h0010; cs_n = 1'b0;
    cycles(2);
    rd_n = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      cycles(1);
      if (ur_c === 1'b1 && first_ur < 0) first_ur = cyc;
      if (ad_out_c === 16'h1234 && first_dat < 0) first_dat = cyc;
    end
    checks++;
    if (ur_cnt_c - u0 !== 1) begin errors++; $display("FAIL underrun_pulses got %0d want 1", ur_cnt_c - u0); end
    checks++;
    if (first_dat - first_ur !== 3) begin
      errors++; $display("FAIL underrun_land got %0d cycles want 3", first_dat - first_ur);
    end
    checks++;
    if (ad_out_c !== 16'h1234) begin errors++; $display("FAIL underrun_data got %h want 1234", ad_out_c); end
    rd_n = 1'b1;
    cycles(8);
    bus_release();
  endtask

  task automatic test_cs_abort();
    logic [15:0] wa, wb, wc;
    logic        oe;
    ah = 8'h00; ad_in = 16'h0011; cs_n = 1'b0;
    cycles(2);
    cs_n = 1'b1;
    cycles(12);
    checks++;
    if (ad_out_c !== 16'h1234) begin errors++; $display("FAIL abort_hold_c got %h want 1234", ad_out_c); end
    bus_select(8'h00, 16'h0020);
    read_word(wa, wb, wc, oe);
    checks++;
    if (wc !== 16'h2020) begin errors++; $display("FAIL abort_new_c got %h want 2020", wc); end
    checks++;
    if (wa !== 16'h2020) begin errors++; $display("FAIL abort_new_a got %h want 2020", wa); end
    checks++;
    if (wb !== 16'h2020) begin errors++; $display("FAIL abort_new_b got %h want 2020", wb); end
    bus_release();
  endtask

  task automatic test_reset_mid();
    bus_select(8'h00, 16'h0010);
    rd_n = 1'b0;
    cycles(6);
    rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(10);
    checks++;
    if (ad_out_a !== 16'h0000) begin errors++; $display("FAIL rstmid_ad_out got %h want 0000", ad_out_a); end
    checks++;
    if (rc_a !== 16'd0) begin errors++; $display("FAIL rstmid_read_count got %0d want 0", rc_a); end
    checks++;
    if (ad_oe_a !== 1'b0) begin errors++; $display("FAIL rstmid_oe got %b want 0", ad_oe_a); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem_a[i] = 16'hDEAD;
      mem_c[i] = 16'hDEAD;
    end
    for (int i = 0; i < 65536; i++) mem_b[i] = 16'hDEAD;
    for (int i = 0; i < 4; i++) pipe_c[i] = 16'h0BAD;
    rdata_a = 16'h0BAD;
    rdata_b = 16'h0BAD;
    mem_a[16'h010] = 16'h1234; mem_b[16'h0010] = 16'h1234; mem_c[16'h010] = 16'h1234;
    mem_a[16'h011] = 16'hABCD; mem_b[16'h0011] = 16'hABCD; mem_c[16'h011] = 16'hABCD;
    mem_a[16'h020] = 16'h2020; mem_b[16'h0020] = 16'h2020; mem_c[16'h020] = 16'h2020;
    mem_b[16'hFFFF] = 16'hF00F;
    mem_b[16'h0000] = 16'h0A0A;
    mem_b[16'h0001] = 16'h1B1B;

    test_reset();
    test_basic();
    test_wrap();
    test_out_of_range();
    test_underrun();
    test_cs_abort();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
